// File: rtl/color_lookup_arbiter.sv
// Shares the synchronous colour table between the pixel stream (absolute priority) and a debug readback port.
// Optional debug starvation monitor is enabled by defining COLOR_ARB_STARVE_EN.
module color_lookup_arbiter #(
  parameter int TBL_LAT      = 1,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode_in,
  input  logic        frame_start,
  input  logic        px_valid,
  input  logic [3:0]  px_lum,
  input  logic [3:0]  px_hue,
  input  logic        dbg_req,
  input  logic [1:0]  dbg_mode,
  input  logic [3:0]  dbg_lum,
  input  logic [3:0]  dbg_hue,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [23:0] dbg_rdata,
  output logic        dbg_starve,
  output logic [3:0]  tbl_lum,
  output logic [3:0]  tbl_hue,
  output logic [1:0]  tbl_mode,
  input  logic [23:0] tbl_color,
  output logic        px_out_valid,
  output logic [23:0] px_color,
  output logic [1:0]  mode_active
);

  logic              issue_px;
  logic              issue_dbg;
  logic [1:0]        mode_act;
  logic [3:0]        lum_p0;
  logic [3:0]        hue_p0;
  logic [1:0]        mode_p0;
  logic [TBL_LAT:0]  px_tag_p;
  logic [TBL_LAT:0]  dbg_tag_p;
  logic              vld_px_p1;
  logic [23:0]       px_color_p1;
  logic              vld_dbg_p1;
  logic [23:0]       dbg_rdata_p1;
  logic              starve_q;

  assign issue_px  = px_valid & ~reset;
  assign issue_dbg = dbg_req & ~px_valid & ~reset;

  // Mode only changes at frame boundaries; reserved mode 3 falls back to NTSC.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_act <= 2'd0;
    end else if (frame_start) begin
      mode_act <= (mode_in == 2'd3) ? 2'd0 : mode_in;
    end
  end

  // Stage p0: table operand registers, held when nothing is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      lum_p0  <= 4'd0;
      hue_p0  <= 4'd0;
      mode_p0 <= 2'd0;
    end else if (issue_px) begin
      lum_p0  <= px_lum;
      hue_p0  <= px_hue;
      mode_p0 <= mode_act;
    end else if (issue_dbg) begin
      lum_p0  <= dbg_lum;
      hue_p0  <= dbg_hue;
      mode_p0 <= dbg_mode;
    end
  end

  // Tag pipeline: tag[TBL_LAT] lines up with the table output for that lookup
  always_ff @(posedge clk) begin
    if (reset) begin
      px_tag_p  <= '0;
      dbg_tag_p <= '0;
    end else begin
      px_tag_p[0]  <= issue_px;
      dbg_tag_p[0] <= issue_dbg;
      for (int i = 1; i <= TBL_LAT; i++) begin
        px_tag_p[i]  <= px_tag_p[i-1];
        dbg_tag_p[i] <= dbg_tag_p[i-1];
      end
    end
  end

  // Stage p1: route table output to the pixel or debug result register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_px_p1    <= 1'b0;
      px_color_p1  <= 24'd0;
      vld_dbg_p1   <= 1'b0;
      dbg_rdata_p1 <= 24'd0;
    end else begin
      vld_px_p1   <= px_tag_p[TBL_LAT];
      px_color_p1 <= px_tag_p[TBL_LAT] ? tbl_color : 24'd0;
      vld_dbg_p1  <= dbg_tag_p[TBL_LAT];
      if (dbg_tag_p[TBL_LAT]) begin
        dbg_rdata_p1 <= tbl_color;
      end
    end
  end

`ifdef COLOR_ARB_STARVE_EN
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;

  always_comb begin
    wait_nxt = 16'd0;
    if (dbg_req && !issue_dbg) begin
      wait_nxt = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 16'd0;
      starve_q <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      starve_q <= (int'(wait_nxt) >= STARVE_LIMIT);
    end
  end
`else
  assign starve_q = 1'b0;
`endif

  // Outputs read zero for the whole time reset is held, including results already in flight.
  assign dbg_gnt      = issue_dbg;
  assign dbg_rvalid   = vld_dbg_p1 & ~reset;
  assign dbg_rdata    = reset ? 24'd0 : dbg_rdata_p1;
  assign dbg_starve   = starve_q & ~reset;
  assign tbl_lum      = reset ? 4'd0 : lum_p0;
  assign tbl_hue      = reset ? 4'd0 : hue_p0;
  assign tbl_mode     = reset ? 2'd0 : mode_p0;
  assign px_out_valid = vld_px_p1 & ~reset;
  assign px_color     = reset ? 24'd0 : px_color_p1;
  assign mode_active  = reset ? 2'd0 : mode_act;

endmodule

// File: tb/tb_color_lookup_arbiter.sv
// Directed bench for color_lookup_arbiter with a behavioural one-cycle colour table model.
module tb_color_lookup_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode_in;
  logic        frame_start;
  logic        px_valid;
  logic [3:0]  px_lum, px_hue;
  logic        dbg_req;
  logic [1:0]  dbg_mode;
  logic [3:0]  dbg_lum, dbg_hue;
  logic        dbg_gnt, dbg_rvalid, dbg_starve;
  logic [23:0] dbg_rdata;
  logic [3:0]  tbl_lum, tbl_hue;
  logic [1:0]  tbl_mode;
  logic [23:0] tbl_color;
  logic        px_out_valid;
  logic [23:0] px_color;
  logic [1:0]  mode_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  color_lookup_arbiter #(.TBL_LAT(1), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .mode_in(mode_in), .frame_start(frame_start),
    .px_valid(px_valid), .px_lum(px_lum), .px_hue(px_hue),
    .dbg_req(dbg_req), .dbg_mode(dbg_mode), .dbg_lum(dbg_lum), .dbg_hue(dbg_hue),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_starve(dbg_starve),
    .tbl_lum(tbl_lum), .tbl_hue(tbl_hue), .tbl_mode(tbl_mode), .tbl_color(tbl_color),
    .px_out_valid(px_out_valid), .px_color(px_color), .mode_active(mode_active)
  );

  // Partial Atari palette; entries not listed return a recognisable filler pattern.
  function automatic logic [23:0] pal(input logic [1:0] m, input logic [3:0] h, input logic [3:0] l);
    logic [23:0] grey [8];
    logic [23:0] secam [8];
    grey  = '{24'h000000, 24'h404040, 24'h6C6C6C, 24'h909090,
              24'hB0B0B0, 24'hC8C8C8, 24'hDCDCDC, 24'hECECEC};
    secam = '{24'h000000, 24'h2121FF, 24'hF03C79, 24'hFF50FF,
              24'h7FFF00, 24'h7FFFFF, 24'hFFFF3F, 24'hFFFFFF};
    if (m == 2'd0 && h == 4'd0) return grey[l[3:1]];
    if (m == 2'd0 && h == 4'd1 && l[3:1] == 3'd0) return 24'h444400;
    if (m == 2'd0 && h == 4'd2 && l[3:1] == 3'd0) return 24'h702800;
    if (m == 2'd1 && h == 4'd2 && l[3:1] == 3'd0) return 24'h805800;
    if (m == 2'd2) return secam[l[3:1]];
    return {6'h2A, m, h, l, 8'h5A};
  endfunction

  always_ff @(posedge clk) tbl_color <= pal(tbl_mode, tbl_hue, tbl_lum);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0; px_valid = 1'b0; px_lum = 4'd0; px_hue = 4'd0;
    dbg_req = 1'b0; dbg_mode = 2'd0; dbg_lum = 4'd0; dbg_hue = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode_in = 2'd0; idle_inputs();
    step(); step();
    #1;
    checks++;
    if ({px_out_valid, px_color, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_starve,
         tbl_lum, tbl_hue, tbl_mode, mode_active} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: px_v=%b px=%h gnt=%b rv=%b rd=%h st=%b tbl=%h/%h/%h ma=%0d, want all 0",
               px_out_valid, px_color, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_starve,
               tbl_lum, tbl_hue, tbl_mode, mode_active);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_pixel();
    for (int c = 0; c < 16; c++) begin
      px_valid = (c == 10); px_lum = 4'hE; px_hue = 4'h0;
      #1;
      checks++;
      if (px_out_valid !== (c == 13)) begin
        errors++; $display("FAIL single_valid c=%0d: got %b want %b", c, px_out_valid, (c == 13));
      end
      checks++;
      if (px_color !== ((c == 13) ? 24'hECECEC : 24'h000000)) begin
        errors++; $display("FAIL single_color c=%0d: got %h", c, px_color);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_pixel_priority();
    for (int c = 0; c < 26; c++) begin
      px_valid = (c <= 19); px_lum = 4'h2; px_hue = 4'h0;
      dbg_req = (c >= 2 && c <= 20); dbg_mode = 2'd2; dbg_lum = 4'h4; dbg_hue = 4'h3;
      #1;
      checks++;
      if (dbg_gnt !== (c == 20)) begin
        errors++; $display("FAIL prio_gnt c=%0d: got %b want %b", c, dbg_gnt, (c == 20));
      end
      checks++;
      if (px_out_valid !== (c >= 3 && c <= 22)) begin
        errors++; $display("FAIL prio_px_valid c=%0d: got %b", c, px_out_valid);
      end
      if (c >= 3 && c <= 22) begin
        checks++;
        if (px_color !== 24'h404040) begin
          errors++; $display("FAIL prio_px_color c=%0d: got %h want 404040", c, px_color);
        end
      end
      checks++;
      if (dbg_rvalid !== (c == 23)) begin
        errors++; $display("FAIL prio_rvalid c=%0d: got %b", c, dbg_rvalid);
      end
      if (c >= 23) begin
        checks++;
        if (dbg_rdata !== 24'hF03C79) begin
          errors++; $display("FAIL prio_rdata c=%0d: got %h want F03C79", c, dbg_rdata);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_mode_switch();
    for (int c = 0; c < 57; c++) begin
      mode_in = (c >= 5) ? 2'd1 : 2'd0; frame_start = (c == 50);
      px_valid = (c == 49 || c == 51); px_lum = 4'h0; px_hue = 4'h2;
      #1;
      checks++;
      if (px_out_valid !== (c == 52 || c == 54)) begin
        errors++; $display("FAIL mode_px_valid c=%0d: got %b", c, px_out_valid);
      end
      if (c == 52 || c == 54) begin
        checks++;
        if (px_color !== ((c == 52) ? 24'h702800 : 24'h805800)) begin
          errors++; $display("FAIL mode_px_color c=%0d: got %h", c, px_color);
        end
      end
      if (c == 50 || c == 51) begin
        checks++;
        if (mode_active !== ((c == 51) ? 2'd1 : 2'd0)) begin
          errors++; $display("FAIL mode_active c=%0d: got %0d", c, mode_active);
        end
      end
      if (c == 50 || c == 52) begin
        checks++;
        if (tbl_mode !== ((c == 52) ? 2'd1 : 2'd0)) begin
          errors++; $display("FAIL mode_tbl_mode c=%0d: got %0d", c, tbl_mode);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_mode_remap();
    for (int c = 0; c < 8; c++) begin
      mode_in = 2'd3; frame_start = (c == 1);
      px_valid = (c == 3); px_lum = 4'h0; px_hue = 4'h1;
      #1;
      if (c == 2) begin
        checks++;
        if (mode_active !== 2'd0) begin
          errors++; $display("FAIL remap_mode c=%0d: got %0d want 0", c, mode_active);
        end
      end
      if (c == 4) begin
        checks++;
        if (tbl_mode !== 2'd0) begin
          errors++; $display("FAIL remap_tbl_mode: got %0d want 0", tbl_mode);
        end
      end
      checks++;
      if (px_out_valid !== (c == 6) || px_color !== ((c == 6) ? 24'h444400 : 24'h0)) begin
        errors++; $display("FAIL remap_px c=%0d: got %b/%h want %b", c, px_out_valid, px_color, (c == 6));
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_px;
    for (int c = 0; c < 9; c++) begin
      px_valid = (c <= 2 || c == 4); px_hue = 4'h0;
      case (c)
        0: px_lum = 4'h2;
        1: px_lum = 4'h4;
        2: px_lum = 4'h6;
        default: px_lum = 4'hE;
      endcase
      dbg_req = (c == 1 || c == 3); dbg_mode = 2'd2; dbg_hue = 4'h0;
      dbg_lum = (c == 1) ? 4'h8 : 4'h2;
      #1;
      case (c)
        3: exp_px = 24'h404040;
        4: exp_px = 24'h6C6C6C;
        5: exp_px = 24'h909090;
        7: exp_px = 24'hECECEC;
        default: exp_px = 24'h000000;
      endcase
      checks++;
      if (px_color !== exp_px || px_out_valid !== (c == 3 || c == 4 || c == 5 || c == 7)) begin
        errors++; $display("FAIL b2b_px c=%0d: got %b/%h want %h", c, px_out_valid, px_color, exp_px);
      end
      checks++;
      if (dbg_gnt !== (c == 3)) begin
        errors++; $display("FAIL b2b_gnt c=%0d: got %b want %b", c, dbg_gnt, (c == 3));
      end
      checks++;
      if (dbg_rvalid !== (c == 6)) begin
        errors++; $display("FAIL b2b_rvalid c=%0d: got %b", c, dbg_rvalid);
      end
      if (c >= 6) begin
        checks++;
        if (dbg_rdata !== 24'h2121FF) begin
          errors++; $display("FAIL b2b_rdata c=%0d: got %h want 2121FF", c, dbg_rdata);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 11; c++) begin
      mode_in = 2'd2; frame_start = (c == 0);
      px_valid = (c <= 2); px_lum = 4'hE; px_hue = 4'h0;
      reset = (c == 3 || c == 4); dbg_req = (c == 3);
      dbg_mode = 2'd0; dbg_lum = 4'h0; dbg_hue = 4'h0;
      #1;
      checks++;
      if (px_out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_px_valid c=%0d: got %b want 0", c, px_out_valid);
      end
      if (c == 2) begin
        checks++;
        if (mode_active !== 2'd2) begin
          errors++; $display("FAIL rstmid_mode_pre c=%0d: got %0d want 2", c, mode_active);
        end
      end
      if (reset) begin
        checks++;
        if ({px_color, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_starve,
             tbl_lum, tbl_hue, tbl_mode, mode_active} !== '0) begin
          errors++;
          $display("FAIL rstmid_outputs c=%0d: px=%h gnt=%b rv=%b rd=%h tbl=%h/%h/%h ma=%0d, want all 0",
                   c, px_color, dbg_gnt, dbg_rvalid, dbg_rdata, tbl_lum, tbl_hue, tbl_mode, mode_active);
        end
      end
      if (c == 6) begin
        checks++;
        if (mode_active !== 2'd0 || dbg_rdata !== 24'd0) begin
          errors++; $display("FAIL rstmid_after c=%0d: ma=%0d rd=%h want 0/0", c, mode_active, dbg_rdata);
        end
      end
      step();
    end
    reset = 1'b0; mode_in = 2'd0; idle_inputs();
  endtask

  task automatic test_starve();
    logic exp_st;
    for (int c = 0; c < 24; c++) begin
      px_valid = (c <= 19); px_lum = 4'h0; px_hue = 4'h0;
      dbg_req = (c <= 20); dbg_mode = 2'd0; dbg_lum = 4'h0; dbg_hue = 4'h0;
      #1;
`ifdef COLOR_ARB_STARVE_EN
      exp_st = (c >= 8 && c <= 20);
`else
      exp_st = 1'b0;
`endif
      checks++;
      if (dbg_starve !== exp_st) begin
        errors++; $display("FAIL starve c=%0d: got %b want %b", c, dbg_starve, exp_st);
      end
      checks++;
      if (dbg_gnt !== (c == 20)) begin
        errors++; $display("FAIL starve_gnt c=%0d: got %b want %b", c, dbg_gnt, (c == 20));
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pixel();
    test_pixel_priority();
    test_mode_switch();
    test_mode_remap();
    test_back_to_back();
    test_reset_mid();
    test_starve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
